// File: rtl/spi_reg_responder.sv
// 3-wire SPI register responder: oversamples SCLK/CSB/SDI in the clk domain, decodes a 16-bit
// instruction plus data bytes, holds a byte-wide register file and answers reads on sdo.
`timescale 1ns/1ps
module spi_reg_responder #(
  parameter int aw       = 8,
  parameter int sync_len = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          csb,
  input  logic          sdi,
  output logic          sdo,
  output logic          sdo_oe,
  output logic          wr_stb,
  output logic [aw-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [aw-1:0] peek_addr,
  output logic [7:0]    peek_data,
  output logic          busy,
  output logic          frame_err
);

  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;

  localparam logic [aw-1:0] ADDR_ONE = {{(aw-1){1'b0}}, 1'b1};

  state_t state, nxt;

  logic [sync_len-1:0] sclk_sr, csb_sr, sdi_sr;
  logic sclk_s, csb_s, sdi_s, sclk_d, csb_d;
  logic sclk_rise, sclk_fall, csb_fall;

  logic [3:0]    cnt, cnt_n;
  logic [14:0]   sh, sh_n;
  logic [15:0]   sh_in;
  logic [aw-1:0] addr, addr_n, addr_dec;
  logic [1:0]    left, left_n;
  logic          stream, stream_n;
  logic          sdo_n, wr_stb_n, ferr_n;
  logic [aw-1:0] wr_addr_n;
  logic [7:0]    wr_data_n;

  logic [7:0] mem [0:(1<<aw)-1];

  // Sync chains reset to 0 so a csb already held low after reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sr <= '0;
      csb_sr  <= '0;
      sdi_sr  <= '0;
      sclk_d  <= 1'b0;
      csb_d   <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[sync_len-2:0], sclk};
      csb_sr  <= {csb_sr[sync_len-2:0], csb};
      sdi_sr  <= {sdi_sr[sync_len-2:0], sdi};
      sclk_d  <= sclk_s;
      csb_d   <= csb_s;
    end
  end

  assign sclk_s    = sclk_sr[sync_len-1];
  assign csb_s     = csb_sr[sync_len-1];
  assign sdi_s     = sdi_sr[sync_len-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csb_fall  = ~csb_s & csb_d;
  assign sh_in     = {sh, sdi_s};
  assign addr_dec  = addr - ADDR_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    cnt_n     = cnt;
    sh_n      = sh;
    addr_n    = addr;
    left_n    = left;
    stream_n  = stream;
    sdo_n     = sdo;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    ferr_n    = frame_err;
    if (csb_s) begin
      // csb high outranks any sclk edge on the same clk; a partial byte is dropped
      if (state != IDLE) nxt = IDLE;
      if (state != IDLE && cnt != 4'd0) ferr_n = 1'b1;
      cnt_n = 4'd0;
    end else begin
      case (state)
        IDLE: if (csb_fall) begin
          nxt   = INSTR;
          cnt_n = 4'd0;
          sh_n  = '0;
        end
        INSTR: if (sclk_rise) begin
          sh_n  = sh_in[14:0];
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            cnt_n    = 4'd0;
            addr_n   = sh_in[aw-1:0];
            left_n   = sh_in[14:13];
            stream_n = &sh_in[14:13];
            if (sh_in[15]) begin
              nxt  = RDATA;
              sh_n = {7'd0, mem[sh_in[aw-1:0]]};
            end else begin
              nxt = WDATA;
            end
          end
        end
        WDATA: if (sclk_rise) begin
          sh_n  = sh_in[14:0];
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n     = 4'd0;
            wr_stb_n  = 1'b1;
            wr_addr_n = addr;
            wr_data_n = sh_in[7:0];
            addr_n    = addr_dec;
            if (!stream) begin
              if (left == 2'd0) nxt = DONE;
              else              left_n = left - 2'd1;
            end
          end
        end
        RDATA: begin
          if (sclk_fall) begin
            sdo_n = sh[7];
            sh_n  = {sh[13:0], 1'b0};
          end else if (sclk_rise) begin
            cnt_n = cnt + 4'd1;
            // initiator has taken the 8th bit: preload the next byte before the following fall
            if (cnt == 4'd7) begin
              cnt_n  = 4'd0;
              addr_n = addr_dec;
              sh_n   = {7'd0, mem[addr_dec]};
              if (!stream) begin
                if (left == 2'd0) nxt = DONE;
                else              left_n = left - 2'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
    if (nxt != RDATA) sdo_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      sh        <= '0;
      addr      <= '0;
      left      <= 2'd0;
      stream    <= 1'b0;
      sdo       <= 1'b0;
      sdo_oe    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      peek_data <= 8'd0;
    end else begin
      cnt       <= cnt_n;
      sh        <= sh_n;
      addr      <= addr_n;
      left      <= left_n;
      stream    <= stream_n;
      sdo       <= sdo_n;
      sdo_oe    <= (nxt == RDATA);
      wr_stb    <= wr_stb_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      frame_err <= ferr_n;
      busy      <= ~csb_s;
      peek_data <= mem[peek_addr];
    end
  end

  // Register file is plain RAM, never cleared; peek reads the pre-write value on a collision.
  always_ff @(posedge clk) begin
    if (rst_n && wr_stb_n) mem[wr_addr_n] <= wr_data_n;
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: table of SPI frames plus hand sequences for
// framing errors, peek/write collision and reset in the middle of a read.
`timescale 1ns/1ps
module tb_spi_reg_responder;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst_n, sclk, csb, sdi;
  logic       sdo, sdo_oe, wr_stb, busy, frame_err;
  logic [7:0] wr_addr, wr_data, peek_addr, peek_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] wq [$];
  logic [7:0]  peek_at_stb, peek_after;
  logic        cap_next = 1'b0;

  spi_reg_responder #(.aw(8), .sync_len(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .csb(csb), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .peek_addr(peek_addr), .peek_data(peek_data), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_next) begin
      peek_after <= peek_data;
      cap_next   <= 1'b0;
    end
    if (wr_stb) begin
      wq.push_back({wr_addr, wr_data});
      peek_at_stb <= peek_data;
      cap_next    <= 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic sbit(input logic d, output logic q, output logic oe);
    sdi = d;
    clk_n(HALF);
    #1;
    q  = sdo;
    oe = sdo_oe;
    sclk = 1'b1;
    clk_n(HALF);
    #1;
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [15:0] ins, input int nby, input logic [3:0][7:0] wd,
                       output logic [3:0][7:0] rd, output int oe_bad);
    logic q, oe;
    oe_bad = 0;
    rd = '0;
    csb = 1'b0;
    clk_n(4);
    for (int i = 15; i >= 0; i--) begin
      sbit(ins[i], q, oe);
      if (oe) oe_bad++;
    end
    for (int b = 0; b < nby; b++)
      for (int j = 7; j >= 0; j--) begin
        sbit(wd[b][j], q, oe);
        rd[b][j] = q;
        if (oe != ins[15]) oe_bad++;
      end
    clk_n(HALF);
    csb = 1'b1;
    clk_n(8);
  endtask

  typedef struct {
    logic            rw;
    logic [1:0]      w;
    logic [12:0]     addr;
    int              nby;
    logic [3:0][7:0] d;   // write data or expected read data, byte 0 first
    logic [3:0][7:0] ea;  // expected wr_addr per byte
  } vec_t;

  vec_t vt [8];
  logic [3:0][7:0] rd;
  int ob;
  logic q, oe;
  logic [7:0] ra, rv;

  initial begin
    vt[0] = '{1'b0, 2'd0, 13'h00FF, 1, 32'h0000005C, 32'h000000FF};
    vt[1] = '{1'b0, 2'd0, 13'h0014, 1, 32'h000000A5, 32'h00000014};
    vt[2] = '{1'b0, 2'd2, 13'h0002, 3, 32'h00332211, 32'h00000102};
    vt[3] = '{1'b1, 2'd3, 13'h0002, 4, 32'h5C332211, 32'h00000000};
    vt[4] = '{1'b1, 2'd0, 13'h0014, 1, 32'h000000A5, 32'h00000000};
    vt[5] = '{1'b0, 2'd1, 13'h01FE, 2, 32'h00008877, 32'h0000FDFE};
    vt[6] = '{1'b1, 2'd1, 13'h00FE, 2, 32'h00008877, 32'h00000000};
    vt[7] = '{1'b1, 2'd0, 13'h1114, 1, 32'h000000A5, 32'h00000000};

    rst_n = 1'b0; csb = 1'b1; sclk = 1'b0; sdi = 1'b0; peek_addr = 8'h00;
    clk_n(4);
    #1;
    chk("rst_sdo", sdo, 0);
    chk("rst_sdo_oe", sdo_oe, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    clk_n(6);

    for (int i = 0; i < 8; i++) begin
      wq.delete();
      frame({vt[i].rw, vt[i].w, vt[i].addr}, vt[i].nby, vt[i].d, rd, ob);
      chk($sformatf("v%0d_oe_phase", i), ob, 0);
      chk($sformatf("v%0d_oe_idle", i), sdo_oe, 0);
      if (vt[i].rw) begin
        for (int b = 0; b < vt[i].nby; b++)
          chk($sformatf("v%0d_rd_b%0d", i, b), rd[b], vt[i].d[b]);
      end else begin
        chk($sformatf("v%0d_stb_count", i), wq.size(), vt[i].nby);
        for (int b = 0; b < vt[i].nby && b < wq.size(); b++) begin
          chk($sformatf("v%0d_wr_addr%0d", i, b), wq[b][15:8], vt[i].ea[b]);
          chk($sformatf("v%0d_wr_data%0d", i, b), wq[b][7:0], vt[i].d[b]);
          peek_addr = vt[i].ea[b];
          clk_n(2);
          #1;
          chk($sformatf("v%0d_peek%0d", i, b), peek_data, vt[i].d[b]);
        end
      end
      chk($sformatf("v%0d_frame_err", i), frame_err, 0);
    end

    // csb rises after 5 bits of a write data byte
    wq.delete();
    csb = 1'b0;
    clk_n(4);
    for (int i = 15; i >= 0; i--) sbit(ra_bit(16'h0030, i), q, oe);
    for (int j = 7; j >= 3; j--) sbit(rv_bit(8'h3C, j), q, oe);
    clk_n(HALF);
    csb = 1'b1;
    clk_n(8);
    chk("ferr_no_stb", wq.size(), 0);
    chk("ferr_set", frame_err, 1);
    frame(16'h0030, 1, 32'h0000003C, rd, ob);
    chk("ferr_recover_stb", wq.size(), 1);
    if (wq.size() > 0) chk("ferr_recover_data", wq[0], 16'h303C);
    chk("ferr_sticky", frame_err, 1);

    // write and peek on the same address: old value first, new value next clk
    wq.delete();
    peek_addr = 8'h14;
    frame(16'h0014, 1, 32'h0000005A, rd, ob);
    chk("coll_stb", wq.size(), 1);
    chk("coll_peek_old", peek_at_stb, 8'hA5);
    chk("coll_peek_new", peek_after, 8'h5A);

    // reset in the middle of a read with csb held low
    csb = 1'b0;
    clk_n(4);
    for (int i = 15; i >= 0; i--) sbit(ra_bit(16'h8014, i), q, oe);
    for (int j = 0; j < 3; j++) sbit(1'b0, q, oe);
    chk("mid_read_oe", sdo_oe, 1);
    rst_n = 1'b0;
    clk_n(2);
    #1;
    chk("rst_mid_oe", sdo_oe, 0);
    rst_n = 1'b1;
    clk_n(2);
    #1;
    chk("rst_mid_ferr_clr", frame_err, 0);
    wq.delete();
    ob = 0;
    for (int i = 15; i >= 0; i--) begin sbit(ra_bit(16'h0050, i), q, oe); if (oe) ob++; end
    for (int j = 7; j >= 0; j--) begin sbit(rv_bit(8'hEE, j), q, oe); if (oe) ob++; end
    chk("rst_ignore_stb", wq.size(), 0);
    chk("rst_ignore_oe", ob, 0);
    clk_n(HALF);
    csb = 1'b1;
    clk_n(8);
    chk("rst_ignore_ferr", frame_err, 0);
    frame(16'h8014, 1, '0, rd, ob);
    chk("post_rst_read", rd[0], 8'h5A);
    chk("post_rst_oe", ob, 0);

    // random write/read pairs
    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom_range(0, 255));
      rv = 8'($urandom_range(0, 255));
      frame({8'h00, ra}, 1, {24'h0, rv}, rd, ob);
      frame({8'h80, ra}, 1, '0, rd, ob);
      chk($sformatf("rand%0d_a%0h", k, ra), rd[0], rv);
    end
    chk("final_frame_err", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic logic ra_bit(input logic [15:0] v, input int i);
    return v[i];
  endfunction

  function automatic logic rv_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
